// File: rtl/udp_payload_pkt_fifo_if.sv
// rtl/udp_payload_pkt_fifo_if.sv - AXI-Stream beat bundle used on both sides of the packet FIFO
interface udp_payload_pkt_fifo_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/udp_payload_pkt_fifo.sv
// rtl/udp_payload_pkt_fifo.sv - store-and-forward payload FIFO, whole-packet drop on overflow
// Never backpressures the source; packets become readable only after their tlast beat is written.
module udp_payload_pkt_fifo #(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int DEPTH_WORDS       = 512,
  parameter int DROP_CNT_WIDTH    = 16
) (
  input  logic                            clk_i,
  input  logic                            s_rst_n_i,
  udp_payload_pkt_fifo_if.slave           s_axis,
  udp_payload_pkt_fifo_if.master          m_axis,
  output logic [$clog2(DEPTH_WORDS):0]    pkt_count_o,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count_o,
  output logic                            overflow_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = AW + 1;
  localparam int KW = STREAM_DATA_WIDTH / 8;
  localparam int EW = STREAM_DATA_WIDTH + KW + 1;

  typedef enum logic [1:0] {WR_IDLE, WR_PACKET, WR_DROP} wr_state_e;

  logic [EW-1:0]             mem_q [DEPTH_WORDS];
  wr_state_e                 state_q, state_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]             commit_rd_q;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic                      ready_q;
  logic                      out_valid_q, out_valid_d;
  logic [EW-1:0]             out_data_q;
  logic [PW-1:0]             pkt_count_q, pkt_count_d;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                      overflow_q, overflow_d;

  logic          accept, full, mem_we, commit, drop_inc;
  logic          take, load, pop;
  logic [PW-1:0] used;

  assign accept = s_axis.tvalid & ready_q;
  assign used   = wr_ptr_q - rd_ptr_q;
  assign full   = (used == PW'(DEPTH_WORDS));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    drop_inc     = 1'b0;
    overflow_d   = 1'b0;
    unique case (state_q)
      WR_IDLE, WR_PACKET: begin
        if (accept) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis.tlast) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              commit       = 1'b1;
              state_d      = WR_IDLE;
            end else begin
              state_d = WR_PACKET;
            end
          end else begin
            // Rewind over the partial packet; committed packets stay intact.
            wr_ptr_d   = commit_ptr_q;
            overflow_d = 1'b1;
            if (s_axis.tlast) begin
              drop_inc = 1'b1;
              state_d  = WR_IDLE;
            end else begin
              state_d = WR_DROP;
            end
          end
        end
      end
      WR_DROP: begin
        if (accept && s_axis.tlast) begin
          drop_inc = 1'b1;
          state_d  = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // The reader compares against a one-cycle-old commit pointer, giving the two-edge release latency.
  assign take = out_valid_q & m_axis.tready;
  assign load = (!out_valid_q || take) && (rd_ptr_q != commit_rd_q);
  assign pop  = take & out_data_q[EW-1];

  always_comb begin
    rd_ptr_d     = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    out_valid_d  = load | (out_valid_q & ~take);
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    unique case ({commit, pop})
      2'b10:   pkt_count_d = pkt_count_q + 1'b1;
      2'b01:   pkt_count_d = pkt_count_q - 1'b1;
      default: pkt_count_d = pkt_count_q;
    endcase
    if (drop_inc && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      commit_rd_q  <= '0;
      rd_ptr_q     <= '0;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      commit_rd_q  <= commit_ptr_q;
      rd_ptr_q     <= rd_ptr_d;
      ready_q      <= 1'b1;
      out_valid_q  <= out_valid_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      if (load) begin
        out_data_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign s_axis.tready = ready_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_data_q[EW-1];
  assign m_axis.tkeep  = out_data_q[EW-2 -: KW];
  assign m_axis.tdata  = out_data_q[STREAM_DATA_WIDTH-1:0];
  assign pkt_count_o   = pkt_count_q;
  assign drop_count_o  = drop_count_q;
  assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_udp_payload_pkt_fifo.sv
// tb/tb_udp_payload_pkt_fifo.sv - randomized bench with a queue-based packet model of the FIFO
module tb_udp_payload_pkt_fifo;
  localparam int DEPTH = 8;
  localparam int DCW   = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PW-1:0]  pkt_count;
  logic [DCW-1:0] drop_count;
  logic           overflow;

  udp_payload_pkt_fifo_if #(.DATA_WIDTH(32)) s_if ();
  udp_payload_pkt_fifo_if #(.DATA_WIDTH(32)) m_if ();

  udp_payload_pkt_fifo #(
    .STREAM_DATA_WIDTH(32),
    .DEPTH_WORDS(DEPTH),
    .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk_i(clk),
    .s_rst_n_i(rst_n),
    .s_axis(s_if.slave),
    .m_axis(m_if.master),
    .pkt_count_o(pkt_count),
    .drop_count_o(drop_count),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit ov_seen = 1'b0;
  bit rnd_en = 1'b0;
  logic tready_man = 1'b0;

  // Model: partial packet, committed-but-unloaded beats, output stage, counters.
  beat_t pend[$];
  beat_t cq[$];
  int    vis = 0;
  bit    mdrop = 1'b0;
  bit    m_ov = 1'b0;
  bit    out_v = 1'b0;
  beat_t out_b = '0;
  int    pcnt = 0;
  int    dcnt = 0;
  bit    rdy = 1'b0;

  beat_t got[$];
  int    got_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit accept, full, take, load;
    int vis_n;
    beat_t b;
    if (!rst_n) begin
      pend.delete(); cq.delete();
      vis = 0; mdrop = 0; m_ov = 0; out_v = 0; out_b = '0;
      pcnt = 0; dcnt = 0; rdy = 0;
      return;
    end
    accept = s_if.tvalid && rdy;
    full   = (pend.size() + cq.size()) == DEPTH;
    take   = out_v && m_if.tready;
    load   = (!out_v || take) && (vis > 0);
    vis_n  = cq.size() - (load ? 1 : 0);
    if (take && out_b.last) pcnt--;
    if (load) out_b = cq.pop_front();
    out_v = load || (out_v && !take);
    vis   = vis_n;
    m_ov  = 1'b0;
    b = {s_if.tlast, s_if.tkeep, s_if.tdata};
    if (accept) begin
      if (mdrop) begin
        if (b.last) begin
          mdrop = 1'b0;
          if (dcnt < (1 << DCW) - 1) dcnt++;
        end
      end else if (full) begin
        pend.delete();
        m_ov = 1'b1;
        if (b.last) begin
          if (dcnt < (1 << DCW) - 1) dcnt++;
        end else begin
          mdrop = 1'b1;
        end
      end else begin
        pend.push_back(b);
        if (b.last) begin
          foreach (pend[i]) cq.push_back(pend[i]);
          pend.delete();
          pcnt++;
        end
      end
    end
    rdy = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_if.tready = rnd_en ? ($urandom_range(0, 2) != 0) : tready_man;
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      chk("tready", 64'(s_if.tready), 64'(rdy));
      chk("tvalid", 64'(m_if.tvalid), 64'(out_v));
      chk("pkt_count", 64'(pkt_count), 64'(pcnt));
      chk("drop_count", 64'(drop_count), 64'(dcnt));
      chk("overflow", 64'(overflow), 64'(m_ov));
      if (out_v) begin
        chk("tdata", 64'(m_if.tdata), 64'(out_b.data));
        chk("tkeep", 64'(m_if.tkeep), 64'(out_b.keep));
        chk("tlast", 64'(m_if.tlast), 64'(out_b.last));
      end
      if (overflow === 1'b1) ov_seen = 1'b1;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        got.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input string nm, input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(posedge clk);
    #1;
    chk(nm, 64'(got.size()), 64'(n));
  endtask

  task automatic clear_got();
    got.delete();
    got_cyc.delete();
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
    m_if.tready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    tready_man = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    @(negedge clk);
    chk("post_rst_tready", 64'(s_if.tready), 64'd1);
    @(posedge clk); #1;

    // T1: 4-beat packet, release latency, count 1 -> 0
    clear_got();
    for (int i = 0; i < 4; i++) send_beat(32'h11111111 * (i + 1), 4'hf, i == 3);
    @(negedge clk);
    chk("t1_pkt_count_commit", 64'(pkt_count), 64'd1);
    chk("t1_tvalid_n0", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    chk("t1_tvalid_n1", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    chk("t1_tvalid_n2", 64'(m_if.tvalid), 64'd1);
    wait_got("t1_beats", 4, 50);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("t1_data", 64'(got[i].data), 64'(32'h11111111 * (i + 1)));
      chk("t1_last", 64'(got[i].last), 64'(i == 3));
    end
    idle(2);
    chk("t1_pkt_count_drained", 64'(pkt_count), 64'd0);

    // T2: gaps mid-packet, nothing released until tlast
    clear_got();
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h20000000 + i, 4'(i + 1), 1'b0);
      idle(3);
    end
    chk("t2_no_early_out", 64'(got.size()), 64'd0);
    chk("t2_no_early_valid", 64'(m_if.tvalid), 64'd0);
    send_beat(32'h20000003, 4'h0, 1'b1);
    wait_got("t2_beats", 4, 50);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk("t2_data", 64'(got[i].data), 64'(32'h20000000 + i));
      chk("t2_keep", 64'(got[i].keep), 64'((i + 1) % 4));
    end

    // T3: stalled output, A (6) fits, B (4) dropped whole
    tready_man = 1'b0;
    idle(2);
    clear_got();
    ov_seen = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(32'hA0000000 + i, 4'hf, i == 5);
    for (int i = 0; i < 4; i++) send_beat(32'hB0000000 + i, 4'hf, i == 3);
    idle(3);
    chk("t3_overflow_seen", 64'(ov_seen), 64'd1);
    chk("t3_drop_count", 64'(drop_count), 64'd1);
    chk("t3_pkt_count", 64'(pkt_count), 64'd1);
    tready_man = 1'b1;
    wait_got("t3_beats", 6, 60);
    idle(10);
    chk("t3_only_a", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      chk("t3_data", 64'(got[i].data), 64'(32'hA0000000 + i));
    end

    // T4: three back-to-back 3-beat packets stream with no bubbles
    clear_got();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3; i++) send_beat(32'h40000000 + p * 16 + i, 4'h3, i == 2);
    wait_got("t4_beats", 9, 60);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      chk("t4_contiguous", 64'(got_cyc[i] - got_cyc[0]), 64'(i));
      chk("t4_last", 64'(got[i].last), 64'(i % 3 == 2));
      chk("t4_data", 64'(got[i].data), 64'(32'h40000000 + (i / 3) * 16 + i % 3));
    end

    // T5: reset with one stored packet and one partial packet
    tready_man = 1'b0;
    idle(2);
    clear_got();
    send_beat(32'h50000000, 4'hf, 1'b0);
    send_beat(32'h50000001, 4'hf, 1'b1);
    send_beat(32'h50000002, 4'hf, 1'b0);
    send_beat(32'h50000003, 4'hf, 1'b0);
    rst_n = 1'b0;
    idle(2);
    @(negedge clk);
    chk("t5_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t5_pkt_count", 64'(pkt_count), 64'd0);
    chk("t5_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tready_man = 1'b1;
    idle(1);
    idle(1);
    clear_got();
    for (int i = 0; i < 3; i++) send_beat(32'h60000000 + i, 4'h5, i == 2);
    wait_got("t5_beats", 3, 50);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk("t5_data", 64'(got[i].data), 64'(32'h60000000 + i));
    end

    // T6: 200 random packets under random backpressure
    rnd_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_beat($urandom, 4'($urandom), i == len - 1);
      end
    end
    rnd_en = 1'b0;
    tready_man = 1'b1;
    for (int i = 0; i < 300 && (pcnt != 0 || out_v || cq.size() != 0); i++) @(posedge clk);
    idle(2);
    chk("t6_drained_pkt_count", 64'(pkt_count), 64'd0);
    chk("t6_drained_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t6_drops_seen", 64'(drop_count != '0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
